uart_rx: RTL and testbench

Oversampling UART receiver: detects the start bit, recovers a DATA_WIDTH-bit LSB-first frame with optional parity and one stop bit, checks framing and parity, and delivers the word with a one-cycle valid pulse. It is the receive-side counterpart of the UART transmitter in the UART subsystem. It runs on the RX oversampling clock (baud × PRESCALE) and feeds the system controller's receive path.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_sampler.sv | 93 +++++++++
 rtl/uart_rx.sv | 139 +++++++++++++
 tb/tb_uart_rx.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART encodings: FSM states, legal PRESCALE ratios, parity type
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } rx_state_e;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  // Parity type encoding shared with the transmitter
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - per-bit edge/bit counters and mid-bit sampling for uart_rx
// UART_RX_MAJORITY_EN selects a 3-sample majority vote; otherwise one mid-bit sample.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  active,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  rx_in,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  bit_done,
  output logic                  bit_end_next,
  output logic [BIT_CNT_W-1:0]  bit_cnt
);

  localparam logic [PRESCALE_W-1:0] E_ONE = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] E_TWO = PRESCALE_W'(2);
  localparam logic [BIT_CNT_W-1:0]  B_ONE = BIT_CNT_W'(1);

`ifdef UART_RX_MAJORITY_EN
  localparam int NSAMP = 3;
`else
  localparam int NSAMP = 1;
`endif

  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [NSAMP-1:0]      samp_q, samp_d;
  logic [PRESCALE_W-1:0] half, last;

  assign half = prescale >> 1;
  assign last = prescale - E_ONE;

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    samp_d     = samp_q;
    if (start) begin
      // The detection cycle itself is edge 0 of the start bit
      edge_cnt_d = E_ONE;
      bit_cnt_d  = '0;
    end else if (active) begin
      if (edge_cnt_q == last) begin
        edge_cnt_d = '0;
        bit_cnt_d  = bit_cnt_q + B_ONE;
      end else begin
        edge_cnt_d = edge_cnt_q + E_ONE;
      end
`ifdef UART_RX_MAJORITY_EN
      if (edge_cnt_q == half - E_ONE) samp_d[0] = rx_in;
      if (edge_cnt_q == half)         samp_d[1] = rx_in;
      if (edge_cnt_q == half + E_ONE) samp_d[2] = rx_in;
`else
      if (edge_cnt_q == half)         samp_d[0] = rx_in;
`endif
    end else begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      samp_q     <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      samp_q     <= samp_d;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  assign sampled_bit  = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
  assign sample_valid = active && (edge_cnt_q == half + E_TWO);
`else
  assign sampled_bit  = samp_q[0];
  assign sample_valid = active && (edge_cnt_q == half + E_ONE);
`endif

  // bit_end_next lets the top register a result that is visible on the last edge
  assign bit_done     = active && (edge_cnt_q == last);
  assign bit_end_next = active && (edge_cnt_q == prescale - E_TWO);
  assign bit_cnt      = bit_cnt_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver: start detect, LSB-first deserialize, parity/stop check
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);
  import uart_pkg::*;

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 3);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(DATA_WIDTH);

  rx_state_e             state_q, state_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;

  logic                  frame_start, frame_active;
  logic                  sampled_bit, sample_valid, bit_done, bit_end_next;
  logic [BIT_CNT_W-1:0]  bit_cnt;

  assign frame_start  = (state_q == IDLE) && !RX_IN;
  assign frame_active = (state_q != IDLE);

  uart_rx_sampler #(
    .PRESCALE_W(PRESCALE_W),
    .BIT_CNT_W (BIT_CNT_W)
  ) u_sampler (
    .clk         (CLK),
    .rst         (RST),
    .start       (frame_start),
    .active      (frame_active),
    .prescale    (prescale_q),
    .rx_in       (RX_IN),
    .sampled_bit (sampled_bit),
    .sample_valid(sample_valid),
    .bit_done    (bit_done),
    .bit_end_next(bit_end_next),
    .bit_cnt     (bit_cnt)
  );

  always_comb begin
    state_d      = state_q;
    prescale_d   = prescale_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    shift_d      = shift_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = par_err_q;
    stp_err_d    = stp_err_q;
    case (state_q)
      IDLE: begin
        if (!RX_IN) begin
          state_d    = START;
          prescale_d = PRESCALE;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
        end
      end
      START: begin
        if (sample_valid && sampled_bit) begin
          state_d = IDLE;
        end else if (bit_done) begin
          state_d   = DATA;
          par_err_d = 1'b0;
          stp_err_d = 1'b0;
        end
      end
      DATA: begin
        // Right shift: after DATA_WIDTH bits the first one lands in bit 0
        if (sample_valid) shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
        if (bit_done && bit_cnt == LAST_DATA_BIT) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_done) begin
          if (sampled_bit != (^shift_q ^ par_typ_q)) par_err_d = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        // Decided one edge early so the registered pulse lands on the last stop edge
        if (bit_end_next) begin
          stp_err_d = !sampled_bit;
          if (sampled_bit && !par_err_q) begin
            data_valid_d = 1'b1;
            p_data_d     = shift_q;
          end
        end
        if (bit_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      prescale_q   <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      shift_q      <= '0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prescale_q   <= prescale_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      shift_q      <= shift_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign DATA_VALID = data_valid_q;
  assign PAR_ERR    = par_err_q;
  assign STP_ERR    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx: frame-level model plus literal pins
// Honours UART_RX_MAJORITY_EN for the noise-spike expectation.
module tb_uart_rx;

  localparam int DW = 8;
  localparam int PW = 6;
  localparam int EV_CLR = 0;
  localparam int EV_PAR = 1;
  localparam int EV_FIN = 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          RX_IN = 1'b1;
  logic [PW-1:0] PRESCALE = PW'(8);
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [DW-1:0] P_DATA;
  logic          DATA_VALID, PAR_ERR, STP_ERR;

  uart_rx #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .PRESCALE  (PRESCALE),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_ERR   (PAR_ERR),
    .STP_ERR   (STP_ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Frame-level expectations: absolute cycle at which each visible effect appears
  typedef struct {
    int        at;
    int        kind;
    logic [7:0] data;
    logic      flag;
  } ev_t;
  ev_t ev_q[$];

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } pin_t;
  pin_t pin_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int last_dv_cyc = -1;
  int dv_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: per-cycle model check plus literal pins queued by the stimulus
  initial begin
    logic [7:0] exp_p_data;
    logic       exp_par, exp_stp, exp_dv;
    int         pin_rd;
    exp_p_data = '0;
    exp_par = 1'b0;
    exp_stp = 1'b0;
    pin_rd = 0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        exp_p_data = '0;
        exp_par = 1'b0;
        exp_stp = 1'b0;
      end else begin
        exp_dv = 1'b0;
        foreach (ev_q[i]) begin
          if (ev_q[i].at == cyc) begin
            case (ev_q[i].kind)
              EV_CLR: begin exp_par = 1'b0; exp_stp = 1'b0; end
              EV_PAR: exp_par = ev_q[i].flag;
              default: begin
                exp_stp = !ev_q[i].flag;
                if (ev_q[i].flag && !exp_par) begin
                  exp_dv = 1'b1;
                  exp_p_data = ev_q[i].data;
                end
              end
            endcase
          end
        end
        check("data_valid", {31'd0, DATA_VALID}, {31'd0, exp_dv});
        check("p_data", {24'd0, P_DATA}, {24'd0, exp_p_data});
        check("par_err", {31'd0, PAR_ERR}, {31'd0, exp_par});
        check("stp_err", {31'd0, STP_ERR}, {31'd0, exp_stp});
        if (DATA_VALID === 1'b1) begin
          last_dv_cyc = cyc;
          dv_count++;
        end
      end
      while (pin_rd < pin_q.size()) begin
        check(pin_q[pin_rd].name, pin_q[pin_rd].act, pin_q[pin_rd].exp);
        pin_rd++;
      end
    end
  end

  task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
    pin_t p;
    p.name = name;
    p.act  = act;
    p.exp  = exp;
    pin_q.push_back(p);
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  // Drives one frame starting at the current negedge; abort_bit >= 0 pulses RST inside that bit
  task automatic send_frame(input int p, input bit pe, input bit pt, input logic [7:0] data,
                            input bit pbit, input bit sbit, input logic [7:0] spike,
                            input int abort_bit);
    int          nb;
    int          t;
    logic [15:0] fb;
    logic [7:0]  rxd;
    logic        mis, v;
    nb  = 10 + int'(pe);
    t   = cyc;
    rxd = data;
`ifndef UART_RX_MAJORITY_EN
    rxd = data ^ spike;
`endif
    mis = pe && (pbit != ((^rxd) ^ pt));
    fb = '1;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[1+i] = data[i];
    if (pe) fb[9] = pbit;
    fb[nb-1] = sbit;
    PRESCALE = PW'(p);
    PAR_EN   = pe;
    PAR_TYP  = pt;
    ev_q.push_back('{t + p, EV_CLR, 8'h00, 1'b0});
    if (pe) ev_q.push_back('{t + (nb - 1) * p, EV_PAR, 8'h00, mis});
    ev_q.push_back('{t + nb * p - 1, EV_FIN, rxd, sbit});
    for (int b = 0; b < nb; b++) begin
      for (int e = 0; e < p; e++) begin
        if (b == abort_bit && e == 2) begin
          RST = 1'b1;
          RX_IN = 1'b1;
          ev_q.delete();
          repeat (2) @(negedge CLK);
          RST = 1'b0;
          return;
        end
        v = fb[b];
        if (b >= 1 && b <= 8 && spike[b-1] && e == p / 2) v = ~v;
        RX_IN = v;
        if (b == 0 && e == 1) begin
          PRESCALE = PW'($urandom);
          PAR_EN   = 1'($urandom);
          PAR_TYP  = 1'($urandom);
        end
        @(negedge CLK);
      end
    end
    RX_IN = 1'b1;
  endtask

  task automatic send_glitch(input int p, input int len);
    PRESCALE = PW'(p);
    for (int i = 0; i < len; i++) begin
      RX_IN = 1'b0;
      @(negedge CLK);
    end
    idle(p + 4);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int t0, d1, n_dv;
    int p;
    bit pe, pt, pbit, sbit, good;
    logic [7:0] data, spike;

    RST = 1'b1;
    idle(3);
    RST = 1'b0;
    idle(2);
    pin("reset_p_data", {24'd0, P_DATA}, 32'h0);
    pin("reset_data_valid", {31'd0, DATA_VALID}, 32'h0);
    pin("reset_par_err", {31'd0, PAR_ERR}, 32'h0);
    pin("reset_stp_err", {31'd0, STP_ERR}, 32'h0);

    t0 = cyc;
    send_frame(8, 1, 0, 8'hA5, 0, 1, 8'h00, -1);
    pin("a5_latency", last_dv_cyc - t0, 32'd87);
    pin("a5_data", {24'd0, P_DATA}, 32'hA5);
    pin("a5_par_err", {31'd0, PAR_ERR}, 32'h0);
    pin("a5_stp_err", {31'd0, STP_ERR}, 32'h0);

    n_dv = dv_count;
    send_frame(8, 1, 0, 8'hA5, 1, 1, 8'h00, -1);
    pin("par_err_set", {31'd0, PAR_ERR}, 32'h1);
    pin("par_no_valid", dv_count - n_dv, 32'd0);
    pin("par_keeps_data", {24'd0, P_DATA}, 32'hA5);

    t0 = cyc;
    send_frame(16, 0, 0, 8'h3C, 0, 1, 8'h00, -1);
    d1 = last_dv_cyc;
    pin("3c_latency", d1 - t0, 32'd159);
    pin("3c_data", {24'd0, P_DATA}, 32'h3C);
    send_frame(16, 0, 0, 8'hFF, 0, 1, 8'h00, -1);
    pin("b2b_gap", last_dv_cyc - d1, 32'd160);
    pin("ff_data", {24'd0, P_DATA}, 32'hFF);

    n_dv = dv_count;
    send_glitch(8, 2);
    pin("glitch_no_valid", dv_count - n_dv, 32'd0);
    pin("glitch_keeps_data", {24'd0, P_DATA}, 32'hFF);
    send_frame(8, 0, 0, 8'h96, 0, 1, 8'h00, -1);
    pin("after_glitch_data", {24'd0, P_DATA}, 32'h96);

    n_dv = dv_count;
    send_frame(8, 0, 0, 8'h0F, 0, 0, 8'h04, -1);
    idle(2);
    pin("stp_err_set", {31'd0, STP_ERR}, 32'h1);
    pin("stp_no_valid", dv_count - n_dv, 32'd0);
    pin("stp_keeps_data", {24'd0, P_DATA}, 32'h96);

    send_frame(8, 0, 0, 8'h00, 0, 1, 8'h04, -1);
    pin("stp_err_cleared", {31'd0, STP_ERR}, 32'h0);
`ifdef UART_RX_MAJORITY_EN
    pin("spike_rejected", {24'd0, P_DATA}, 32'h00);
`else
    pin("spike_sampled", {24'd0, P_DATA}, 32'h04);
`endif

    send_frame(8, 1, 0, 8'h33, 0, 1, 8'h00, 5);
    pin("midreset_p_data", {24'd0, P_DATA}, 32'h0);
    pin("midreset_data_valid", {31'd0, DATA_VALID}, 32'h0);
    pin("midreset_par_err", {31'd0, PAR_ERR}, 32'h0);
    pin("midreset_stp_err", {31'd0, STP_ERR}, 32'h0);
    idle(3);
    t0 = cyc;
    send_frame(8, 0, 0, 8'h5A, 0, 1, 8'h00, -1);
    pin("5a_latency", last_dv_cyc - t0, 32'd79);
    pin("5a_data", {24'd0, P_DATA}, 32'h5A);

    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 2))
        0:       p = 8;
        1:       p = 16;
        default: p = 32;
      endcase
      pe    = 1'($urandom_range(0, 1));
      pt    = 1'($urandom_range(0, 1));
      data  = 8'($urandom);
      good  = ($urandom_range(0, 3) != 0);
      pbit  = (^data) ^ pt ^ !good;
      sbit  = ($urandom_range(0, 6) != 0);
      spike = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
      send_frame(p, pe, pt, data, pbit, sbit, spike, -1);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    idle(6);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
